// File: rtl/audio_level_meter.sv
// Stereo peak level meter on the read side of the audio sample FIFO.
// Define AUDIO_PEAK_HOLD_EN to add per-channel peak hold with step decay.
module audio_level_meter #(
    parameter int WINDOW_LOG2  = 8,
    parameter int HOLD_WINDOWS = 4
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        rdempty_sig,
    input  logic [31:0] q_sig,
    output logic        rdreq_sig,
    output logic [3:0]  left_level,
    output logic [3:0]  right_level,
    output logic        level_valid
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] READ    = 3'd1;
    localparam logic [2:0] CAPTURE = 3'd2;
    localparam logic [2:0] ACCUM   = 3'd3;
    localparam logic [2:0] PUBLISH = 3'd4;

    logic [2:0]             r_state;
    logic [31:0]            r_sample;
    logic [14:0]            r_peakL;
    logic [14:0]            r_peakR;
    logic [WINDOW_LOG2-1:0] r_count;

    logic [14:0] w_absL;
    logic [14:0] w_absR;
    logic [3:0]  w_newL;
    logic [3:0]  w_newR;

    // -32768 has no positive counterpart in 16 bits, so it clips to 32767
    function automatic logic [14:0] absSat(input logic [15:0] x);
        logic [15:0] neg;
        neg = (~x) + 16'd1;
        if (!x[15])
            return x[14:0];
        else if (x == 16'h8000)
            return 15'h7FFF;
        else
            return neg[14:0];
    endfunction

    function automatic logic [3:0] bitLen(input logic [14:0] p);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 15; i++)
            if (p[i]) n = 4'(i + 1);
        return n;
    endfunction

    assign w_absL    = absSat(r_sample[31:16]);
    assign w_absR    = absSat(r_sample[15:0]);
    assign w_newL    = bitLen(r_peakL);
    assign w_newR    = bitLen(r_peakR);
    assign rdreq_sig = (r_state == READ);

`ifdef AUDIO_PEAK_HOLD_EN
    logic [3:0] r_holdCntL;
    logic [3:0] r_holdCntR;
    logic [7:0] w_stepL;
    logic [7:0] w_stepR;

    // Returns {held level, hold counter} after one window closes
    function automatic logic [7:0] holdStep(input logic [3:0] held,
                                            input logic [3:0] cnt,
                                            input logic [3:0] lvl);
        logic [3:0] dec;
        dec = held - 4'd1;
        if (lvl >= held)
            return {lvl, 4'd0};
        else if (cnt == 4'(HOLD_WINDOWS - 1))
            return {((dec > lvl) ? dec : lvl), 4'd0};
        else
            return {held, cnt + 4'd1};
    endfunction

    assign w_stepL = holdStep(left_level, r_holdCntL, w_newL);
    assign w_stepR = holdStep(right_level, r_holdCntR, w_newR);
`endif

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= IDLE;
            r_sample    <= '0;
            r_peakL     <= '0;
            r_peakR     <= '0;
            r_count     <= '0;
            left_level  <= '0;
            right_level <= '0;
            level_valid <= 1'b0;
`ifdef AUDIO_PEAK_HOLD_EN
            r_holdCntL  <= '0;
            r_holdCntR  <= '0;
`endif
        end else begin
            level_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!rdempty_sig) r_state <= READ;
                end
                READ: begin
                    r_state <= CAPTURE;
                end
                CAPTURE: begin
                    r_sample <= q_sig;
                    r_state  <= ACCUM;
                end
                ACCUM: begin
                    if (w_absL > r_peakL) r_peakL <= w_absL;
                    if (w_absR > r_peakR) r_peakR <= w_absR;
                    r_count <= r_count + 1'b1;
                    r_state <= (r_count == '1) ? PUBLISH : IDLE;
                end
                PUBLISH: begin
`ifdef AUDIO_PEAK_HOLD_EN
                    left_level  <= w_stepL[7:4];
                    r_holdCntL  <= w_stepL[3:0];
                    right_level <= w_stepR[7:4];
                    r_holdCntR  <= w_stepR[3:0];
`else
                    left_level  <= w_newL;
                    right_level <= w_newR;
`endif
                    level_valid <= 1'b1;
                    r_peakL     <= '0;
                    r_peakR     <= '0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_level_meter.sv
// Randomised and directed bench for audio_level_meter with a FIFO model and
// a window-level reference model; follows AUDIO_PEAK_HOLD_EN when defined.
module tb_audio_level_meter;

    localparam int WIN   = 256;
    localparam int HOLDW = 4;
`ifdef AUDIO_PEAK_HOLD_EN
    localparam bit HOLD_ON = 1'b1;
`else
    localparam bit HOLD_ON = 1'b0;
`endif

    logic        CLOCK_50    = 1'b0;
    logic        RESET_N     = 1'b0;
    logic        rdempty_sig = 1'b1;
    logic [31:0] q_sig       = '0;
    logic        rdreq_sig;
    logic [3:0]  left_level;
    logic [3:0]  right_level;
    logic        level_valid;

    int errors = 0;
    int checks = 0;

    logic [31:0] stim [0:16383];
    int wrPtr = 0;
    int rdPtr = 0;
    bit gapMode = 1'b0;
    bit gap = 1'b0;

    int popsSinceReset = 0;
    int popEmptyViol   = 0;
    int reqViol        = 0;
    logic [31:0] winBuf [$];
    logic [4:0]  expL [$];
    logic [4:0]  expR [$];
    int hL = 0, hcL = 0, hR = 0, hcR = 0;

    int cycle = 0;
    int lastReq = -1;
    int int4 = 0, int5 = 0, intOther = 0;

    int expIdx = 0;
    int lastValidPops = 0;

    audio_level_meter #(.WINDOW_LOG2(8), .HOLD_WINDOWS(HOLDW)) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_N     (RESET_N),
        .rdempty_sig (rdempty_sig),
        .q_sig       (q_sig),
        .rdreq_sig   (rdreq_sig),
        .left_level  (left_level),
        .right_level (right_level),
        .level_valid (level_valid)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic int absVal(input logic [15:0] s);
        int v;
        v = int'($signed(s));
        if (v < 0) v = -v;
        return (v > 32767) ? 32767 : v;
    endfunction

    function automatic int levelOf(input int peak);
        int n;
        n = 0;
        while ((1 << n) <= peak) n++;
        return n;
    endfunction

    task automatic holdModel(inout int held, inout int cnt, input int lvl);
        if (lvl >= held) begin
            held = lvl;
            cnt  = 0;
        end else if (cnt == HOLDW - 1) begin
            held = (held - 1 > lvl) ? held - 1 : lvl;
            cnt  = 0;
        end else begin
            cnt++;
        end
    endtask

    task automatic closeWindow();
        int pL, pR, lvL, lvR, a;
        pL = 0;
        pR = 0;
        foreach (winBuf[i]) begin
            a = absVal(winBuf[i][31:16]);
            if (a > pL) pL = a;
            a = absVal(winBuf[i][15:0]);
            if (a > pR) pR = a;
        end
        lvL = levelOf(pL);
        lvR = levelOf(pR);
        if (HOLD_ON) begin
            holdModel(hL, hcL, lvL);
            holdModel(hR, hcR, lvR);
            lvL = hL;
            lvR = hR;
        end
        expL.push_back(5'(lvL));
        expR.push_back(5'(lvR));
        winBuf.delete();
    endtask

    // FIFO model in normal mode: data appears on q_sig the cycle after rdreq
    always @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            rdPtr          = wrPtr;
            popsSinceReset = 0;
            winBuf.delete();
            expL.delete();
            expR.delete();
            hL = 0; hcL = 0; hR = 0; hcR = 0;
        end else if (rdreq_sig) begin
            if (rdPtr == wrPtr) begin
                popEmptyViol++;
            end else begin
                q_sig <= stim[rdPtr];
                winBuf.push_back(stim[rdPtr]);
                rdPtr++;
                popsSinceReset++;
                if (winBuf.size() == WIN) closeWindow();
            end
        end
    end

    // rdempty_sig is changed only on the falling edge, so the value the DUT
    // sampled at the start of this cycle is still visible here
    always @(negedge CLOCK_50) begin
        cycle++;
        if (!RESET_N) begin
            lastReq  = -1;
            int4     = 0;
            int5     = 0;
            intOther = 0;
        end else if (rdreq_sig) begin
            if (rdempty_sig) reqViol++;
            if (lastReq >= 0) begin
                if (cycle - lastReq == 4) int4++;
                else if (cycle - lastReq == 5) int5++;
                else intOther++;
            end
            lastReq = cycle;
        end
        gap = gapMode && ($urandom_range(2) == 0);
        rdempty_sig = (rdPtr == wrPtr) || gap;
    end

    task automatic applyStimulus(input logic [31:0] word, input int count);
        for (int i = 0; i < count; i++) begin
            stim[wrPtr] = word;
            wrPtr++;
        end
    endtask

    task automatic doReset();
        gapMode = 1'b0;
        RESET_N = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        RESET_N       = 1'b1;
        expIdx        = 0;
        lastValidPops = 0;
    endtask

    task automatic waitValid(output bit ok, output logic [3:0] gotL, output logic [3:0] gotR,
                             output logic [4:0] eL, output logic [4:0] eR,
                             output int pops, output logic after);
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge CLOCK_50);
            #1;
            ok = level_valid;
        end
        gotL = left_level;
        gotR = right_level;
        pops = popsSinceReset - lastValidPops;
        lastValidPops = popsSinceReset;
        if (expIdx < expL.size()) begin
            eL = expL[expIdx];
            eR = expR[expIdx];
            expIdx++;
        end else begin
            eL = 5'h1F;
            eR = 5'h1F;
        end
        @(negedge CLOCK_50);
        #1;
        after = level_valid;
    endtask

    task automatic test_reset();
        bit ok;
        logic [3:0] gL, gR;
        logic [4:0] eL, eR;
        int pops;
        logic after;
        doReset();
        #1;
        checks++;
        if (left_level !== 4'd0 || right_level !== 4'd0 || level_valid !== 1'b0 || rdreq_sig !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: L=%0d R=%0d valid=%b rdreq=%b, expected 0 0 0 0",
                     left_level, right_level, level_valid, rdreq_sig);
        end
        applyStimulus(32'h4000_C000, WIN + 100);
        waitValid(ok, gL, gR, eL, eR, pops, after);
        checks++;
        if (!ok || gL !== 4'd15 || gR !== 4'd15) begin
            errors++;
            $display("[TB] FAIL pre_reset_window: ok=%b L=%0d R=%0d, expected 1 15 15", ok, gL, gR);
        end
        repeat (200) @(negedge CLOCK_50);
        #3 RESET_N = 1'b0;
        #1;
        checks++;
        if (left_level !== 4'd0 || right_level !== 4'd0 || level_valid !== 1'b0 || rdreq_sig !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: L=%0d R=%0d valid=%b rdreq=%b, expected 0 0 0 0",
                     left_level, right_level, level_valid, rdreq_sig);
        end
        @(negedge CLOCK_50);
        RESET_N       = 1'b1;
        expIdx        = 0;
        lastValidPops = 0;
        applyStimulus(32'h0010_0003, WIN);
        waitValid(ok, gL, gR, eL, eR, pops, after);
        checks++;
        if (!ok || pops != WIN) begin
            errors++;
            $display("[TB] FAIL post_reset_pops: ok=%b pops=%0d, expected 1 %0d", ok, pops, WIN);
        end
        checks++;
        if (gL !== 4'd5 || gR !== 4'd2 || {1'b0, gL} !== eL || {1'b0, gR} !== eR) begin
            errors++;
            $display("[TB] FAIL post_reset_levels: L=%0d R=%0d, expected 5 2 (model %0d %0d)", gL, gR, eL, eR);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [3:0] gL, gR;
        logic [4:0] eL, eR;
        int pops;
        logic after;
        doReset();
        applyStimulus(32'h0100_FF00, 2 * WIN);
        for (int w = 0; w < 2; w++) begin
            waitValid(ok, gL, gR, eL, eR, pops, after);
            checks++;
            if (!ok || pops != WIN) begin
                errors++;
                $display("[TB] FAIL b2b_pops w%0d: ok=%b pops=%0d, expected 1 %0d", w, ok, pops, WIN);
            end
            checks++;
            if (gL !== 4'd9 || gR !== 4'd9 || {1'b0, gL} !== eL || {1'b0, gR} !== eR) begin
                errors++;
                $display("[TB] FAIL b2b_levels w%0d: L=%0d R=%0d, expected 9 9 (model %0d %0d)", w, gL, gR, eL, eR);
            end
            checks++;
            if (after !== 1'b0) begin
                errors++;
                $display("[TB] FAIL valid_pulse w%0d: valid next cycle=%b, expected 0", w, after);
            end
        end
        checks++;
        if (int4 != 2 * WIN - 2 || int5 != 1 || intOther != 0) begin
            errors++;
            $display("[TB] FAIL b2b_spacing: gaps4=%0d gaps5=%0d other=%0d, expected %0d 1 0",
                     int4, int5, intOther, 2 * WIN - 2);
        end
    endtask

    task automatic test_min_sample();
        bit ok;
        logic [3:0] gL, gR;
        logic [4:0] eL, eR;
        int pops;
        logic after;
        doReset();
        applyStimulus(32'h0000_0000, 100);
        applyStimulus(32'h8000_0000, 1);
        applyStimulus(32'h0000_0000, WIN - 101);
        applyStimulus(32'h0000_0000, WIN);
        waitValid(ok, gL, gR, eL, eR, pops, after);
        checks++;
        if (!ok || gL !== 4'd15 || gR !== 4'd0 || {1'b0, gL} !== eL || {1'b0, gR} !== eR) begin
            errors++;
            $display("[TB] FAIL min_sample: ok=%b L=%0d R=%0d, expected 1 15 0 (model %0d %0d)", ok, gL, gR, eL, eR);
        end
        waitValid(ok, gL, gR, eL, eR, pops, after);
        checks++;
        if (!ok || gL !== (HOLD_ON ? 4'd15 : 4'd0) || gR !== 4'd0 || {1'b0, gL} !== eL) begin
            errors++;
            $display("[TB] FAIL peak_cleared: ok=%b L=%0d R=%0d, expected 1 %0d 0", ok, gL, gR, HOLD_ON ? 15 : 0);
        end
    endtask

    task automatic test_boundary();
        bit ok;
        logic [3:0] gL, gR;
        logic [4:0] eL, eR;
        int pops;
        logic after;
        doReset();
        applyStimulus(32'h0000_0000, WIN - 1);
        applyStimulus(32'h7FFF_0000, 1);
        applyStimulus(32'h0000_0000, WIN);
        waitValid(ok, gL, gR, eL, eR, pops, after);
        checks++;
        if (!ok || gL !== 4'd15 || gR !== 4'd0 || {1'b0, gL} !== eL) begin
            errors++;
            $display("[TB] FAIL boundary_last: ok=%b L=%0d R=%0d, expected 1 15 0", ok, gL, gR);
        end
        waitValid(ok, gL, gR, eL, eR, pops, after);
        checks++;
        if (!ok || gL !== (HOLD_ON ? 4'd15 : 4'd0) || gR !== 4'd0 || pops != WIN) begin
            errors++;
            $display("[TB] FAIL boundary_next: ok=%b L=%0d R=%0d pops=%0d, expected 1 %0d 0 %0d",
                     ok, gL, gR, pops, HOLD_ON ? 15 : 0, WIN);
        end
    endtask

    task automatic test_random_gaps();
        bit ok;
        logic [3:0] gL, gR;
        logic [4:0] eL, eR;
        int pops;
        logic after;
        logic [15:0] l, r;
        doReset();
        gapMode = 1'b1;
        for (int i = 0; i < 3 * WIN; i++) begin
            l = 16'($signed(16'($urandom)) >>> $urandom_range(15));
            r = 16'($signed(16'($urandom)) >>> $urandom_range(15));
            applyStimulus({l, r}, 1);
        end
        for (int w = 0; w < 3; w++) begin
            waitValid(ok, gL, gR, eL, eR, pops, after);
            checks++;
            if (!ok || pops != WIN || {1'b0, gL} !== eL || {1'b0, gR} !== eR) begin
                errors++;
                $display("[TB] FAIL random_window w%0d: ok=%b pops=%0d L=%0d R=%0d, expected 1 %0d %0d %0d",
                         w, ok, pops, gL, gR, WIN, eL, eR);
            end
        end
        gapMode = 1'b0;
        checks++;
        if (reqViol != 0 || popEmptyViol != 0) begin
            errors++;
            $display("[TB] FAIL rdreq_protocol: req_after_empty=%0d pop_empty=%0d, expected 0 0",
                     reqViol, popEmptyViol);
        end
    endtask

    task automatic test_hold();
        bit ok;
        logic [3:0] gL, gR;
        logic [4:0] eL, eR;
        int pops;
        logic after;
        logic [3:0] want;
        doReset();
        applyStimulus(32'h0800_0800, WIN);
        applyStimulus(32'h0004_0004, 8 * WIN);
        for (int w = 1; w <= 9; w++) begin
            waitValid(ok, gL, gR, eL, eR, pops, after);
            if (HOLD_ON) want = (w <= 4) ? 4'd12 : ((w <= 8) ? 4'd11 : 4'd10);
            else         want = (w == 1) ? 4'd12 : 4'd3;
            checks++;
            if (!ok || gL !== want || gR !== want || {1'b0, gL} !== eL || {1'b0, gR} !== eR) begin
                errors++;
                $display("[TB] FAIL hold_window w%0d: ok=%b L=%0d R=%0d, expected 1 %0d %0d (model %0d %0d)",
                         w, ok, gL, gR, want, want, eL, eR);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_min_sample();
        test_boundary();
        test_random_gaps();
        test_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/audio_level_meter.md
# audio_level_meter

Consumer stage on the read side of the audio sample FIFO. Pops 32-bit stereo words (left in [31:16], right in [15:0], signed two's complement), tracks the per-channel absolute peak over a fixed window of samples and, at window end, publishes a logarithmic 4-bit level per channel for the visualizer bar display. Runs entirely in the FIFO read-clock domain.

## Interface
- WINDOW_LOG2, 8, samples per window = 2**WINDOW_LOG2 (legal 1..12)
- HOLD_WINDOWS, 4, windows a held peak persists before decaying one step (only with AUDIO_PEAK_HOLD_EN; legal 1..15)
- CLOCK_50  input  1  system / FIFO read clock, all logic on rising edge
- RESET_N  input  1  asynchronous, active-low reset
- rdempty_sig  input  1  FIFO empty indicator
- q_sig  input  32  FIFO read data, valid the cycle after rdreq_sig (normal, non-show-ahead mode)
- rdreq_sig  output  1  FIFO read request
- left_level  output  4  published left level, 0..15
- right_level  output  4  published right level, 0..15
- level_valid  output  1  one-cycle pulse when new levels are loaded

## Operation
- FSM states: IDLE, READ, CAPTURE, ACCUM, PUBLISH.
- IDLE: if rdempty_sig==0 -> READ, else stay.
- READ: rdreq_sig=1 for exactly this cycle -> CAPTURE. rdreq_sig is 0 in every other state; never asserted while rdempty_sig==1 was sampled in IDLE.
- CAPTURE: register q_sig -> ACCUM.
- ACCUM: per channel abs = (x<0) ? -x : x; -32768 saturates to 32767 (abs is 15 bits). peak_ch = max(peak_ch, abs). sample counter increments mod 2**WINDOW_LOG2. If counter was 2**WINDOW_LOG2-1 -> PUBLISH, else -> IDLE.
- PUBLISH: level_ch = bit length of peak_ch (peak 0 -> 0; peak in [2**(k-1), 2**k-1] -> k; max 15). Load outputs, clear both peaks to 0 -> IDLE. The final sample of a window is included in that window's peak.
- Counter wraps to 0 at window end; windows are contiguous, no sample dropped or double-counted.
- Channels are fully independent; identical logic instanced twice.

## Timing
- Reset (RESET_N low, asynchronous): state IDLE, rdreq_sig=0, left_level=0, right_level=0, level_valid=0, peaks=0, counter=0, hold registers=0. Reset mid-window discards partial window and any popped-but-unaccumulated sample.
- Per sample: minimum 4 cycles IDLE->READ->CAPTURE->ACCUM->IDLE (5 at window end). Back-to-back non-empty FIFO: one rdreq_sig every 4 cycles (5 across a window boundary).
- Output latency: left_level/right_level update on the clock edge ending PUBLISH; level_valid is 1 for exactly the following cycle, 0 otherwise. Levels hold until next PUBLISH.
- rdempty_sig rising during READ/CAPTURE/ACCUM has no effect on the in-flight sample; it is only sampled in IDLE.

## Configuration
- AUDIO_PEAK_HOLD_EN defined: per channel held level + 4-bit hold counter. At PUBLISH: if new >= held -> held=new, counter=0; else if counter==HOLD_WINDOWS-1 -> held=max(held-1, new), counter=0; else counter++. Outputs show held level.
- Undefined: hold logic absent; outputs equal the just-finished window's level; HOLD_WINDOWS ignored.

## Test plan
- Reset: assert RESET_N=0 mid-window with FIFO non-empty -> all outputs 0 immediately; after release, first level_valid only after 256 further reads.
- Window of 256 words 32'h0100_FF00 (WINDOW_LOG2=8) -> exactly 256 rdreq_sig pulses, then one level_valid with left_level=9, right_level=9.
- One word 32'h8000_0000 inside a window of zeros -> left_level=15, right_level=0; next all-zero window -> 0/0 (peaks cleared).
- Random rdempty_sig gaps -> rdreq_sig never high in a cycle following IDLE with rdempty_sig=1; popped count equals 256 per level_valid; scoreboard levels match model.
- AUDIO_PEAK_HOLD_EN, HOLD_WINDOWS=4: window at level 12 then windows at level 3 -> outputs 12 for windows 1-4, 11 at window 5, 10 at window 9; without macro -> 3 from window 2.
- Window boundary: final sample of window carries the only nonzero value 16'h7FFF left -> that window publishes left_level=15, following window 0.
